// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared widths, FSM states and code constants for the DDR DAC transmitter
package dac_pkg;

   localparam int SAMPLE_W = 14;
   localparam int LANES    = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_UNDER = 2'd3
   } dac_state_e;

   localparam logic [SAMPLE_W-1:0] MIDSCALE_TC = 14'h0000;
   localparam logic [SAMPLE_W-1:0] MIDSCALE_OB = 14'h2000;

   // Offset binary is two's complement with the sign bit flipped.
   function automatic logic [SAMPLE_W-1:0] encode_sample(input logic [SAMPLE_W-1:0] s,
                                                         input logic offset_bin);
      return offset_bin ? {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]} : s;
   endfunction

endpackage

// File: rtl/dac_oddr_lane.sv
// rtl/dac_oddr_lane.sv - one SAME_EDGE DDR output lane: D1 after the rising edge, D2 after the falling edge
module dac_oddr_lane #(
   parameter logic INIT_D1 = 1'b0,
   parameter logic INIT_D2 = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d1_i,
   input  logic d2_i,
   output logic q_o
);

   logic d1_q;
   logic d2_q;

   // Both halves are captured on the same rising edge; the clock level selects which is driven.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d1_q <= INIT_D1;
         d2_q <= INIT_D2;
      end else begin
         d1_q <= d1_i;
         d2_q <= d2_i;
      end
   end

   assign q_o = clk_i ? d1_q : d2_q;

endmodule

// File: rtl/dac_ddr_tx.sv
// rtl/dac_ddr_tx.sv - sample FIFO, prime/run/underrun sequencer and DDR lane driver for a 14-bit DAC
// Optional ramp test pattern on input tp_en when DAC_TESTPAT_EN is defined.
module dac_ddr_tx
   import dac_pkg::*;
#(
   parameter int FIFO_DEPTH    = 8,
   parameter int PRIME_LEVEL   = 4,
   parameter int OFFSET_BIN    = 0,
   parameter int UNDERRUN_HOLD = 1
) (
   input  logic                clk,
   input  logic                rst,
`ifdef DAC_TESTPAT_EN
   input  logic                tp_en,
`endif
   input  logic                en,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [LANES-1:0]    dac_data_out,
   output logic [SAMPLE_W-1:0] dac_word,
   output logic                streaming,
   output logic [15:0]         underrun_cnt
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PTR_W = AW + 1;
   localparam logic [PTR_W-1:0]    PRIME_LVL = PTR_W'(PRIME_LEVEL);
   localparam logic [SAMPLE_W-1:0] MIDSCALE  = (OFFSET_BIN != 0) ? MIDSCALE_OB : MIDSCALE_TC;

   dac_state_e          state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [SAMPLE_W-1:0] word_q, word_d;
   logic [15:0]         ucnt_q, ucnt_d;
   logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0]    occ;
   logic                empty;
   logic                full;
   logic                wr_en;
   logic [SAMPLE_W-1:0] hold_word;

   assign occ   = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Gated by reset so nothing is accepted while the sequencer is held in IDLE.
   assign s_ready   = rst && en && !full;
   assign wr_en     = s_valid && s_ready;
   assign hold_word = (UNDERRUN_HOLD != 0) ? word_q : MIDSCALE;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d = rd_ptr_q;
      word_d   = word_q;
      ucnt_d   = ucnt_q;
      if (!en) begin
         state_d  = ST_IDLE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         word_d   = MIDSCALE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_PRIME;
               word_d  = MIDSCALE;
            end
            ST_PRIME: begin
               if (occ >= PRIME_LVL) state_d = ST_RUN;
            end
            ST_RUN: begin
`ifdef DAC_TESTPAT_EN
               if (tp_en) begin
                  word_d = word_q + SAMPLE_W'(1);
               end else
`endif
               if (!empty) begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                  word_d   = encode_sample(mem_q[rd_ptr_q[AW-1:0]], OFFSET_BIN != 0);
               end else begin
                  state_d = ST_UNDER;
                  word_d  = hold_word;
                  if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
               end
            end
            ST_UNDER: begin
               state_d = ST_PRIME;
               word_d  = hold_word;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         word_q   <= MIDSCALE;
         ucnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         word_q   <= word_d;
         ucnt_q   <= ucnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      dac_oddr_lane #(
         .INIT_D1 (MIDSCALE[2*j]),
         .INIT_D2 (MIDSCALE[2*j+1])
      ) u_lane (
         .clk_i  (clk),
         .rst_ni (rst),
         .d1_i   (word_q[2*j]),
         .d2_i   (word_q[2*j+1]),
         .q_o    (dac_data_out[j])
      );
   end

   assign dac_word     = word_q;
   assign streaming    = (state_q == ST_RUN);
   assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_dac_ddr_tx.sv
// tb/tb_dac_ddr_tx.sv - directed vector bench for dac_ddr_tx (two parameter sets)
module tb_dac_ddr_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic a_en, a_valid, a_ready, a_stream, a_tp;
   logic [13:0] a_data, a_word;
   logic [6:0]  a_lanes;
   logic [15:0] a_cnt;
   logic b_en, b_valid, b_ready, b_stream, b_tp;
   logic [13:0] b_data, b_word;
   logic [6:0]  b_lanes;
   logic [15:0] b_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [13:0] prev_a, prev_b;

   dac_ddr_tx u_a (
      .clk(clk), .rst(rst),
`ifdef DAC_TESTPAT_EN
      .tp_en(a_tp),
`endif
      .en(a_en), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
      .dac_data_out(a_lanes), .dac_word(a_word), .streaming(a_stream), .underrun_cnt(a_cnt)
   );

   dac_ddr_tx #(.FIFO_DEPTH(8), .PRIME_LEVEL(8), .OFFSET_BIN(1), .UNDERRUN_HOLD(0)) u_b (
      .clk(clk), .rst(rst),
`ifdef DAC_TESTPAT_EN
      .tp_en(b_tp),
`endif
      .en(b_en), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
      .dac_data_out(b_lanes), .dac_word(b_word), .streaming(b_stream), .underrun_cnt(b_cnt)
   );

   typedef struct {
      bit          b;
      logic        en, valid;
      logic [13:0] data;
      logic        ready, strm;
      logic [13:0] word;
      logic [15:0] cnt;
   } row_t;
   row_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] even_bits(input logic [13:0] w);
      logic [6:0] r;
      for (int j = 0; j < 7; j++) r[j] = w[2*j];
      return r;
   endfunction

   function automatic logic [6:0] odd_bits(input logic [13:0] w);
      logic [6:0] r;
      for (int j = 0; j < 7; j++) r[j] = w[2*j+1];
      return r;
   endfunction

   task automatic add(input bit b, input logic en, input logic v, input logic [13:0] d,
                      input logic rdy, input logic st, input logic [13:0] w, input logic [15:0] c);
      row_t r;
      r.b = b; r.en = en; r.valid = v; r.data = d;
      r.ready = rdy; r.strm = st; r.word = w; r.cnt = c;
      tbl.push_back(r);
   endtask

   task automatic drive(input bit b, input logic en, input logic v, input logic [13:0] d);
      if (b) begin
         b_en = en; b_valid = v; b_data = d;
      end else begin
         a_en = en; a_valid = v; a_data = d;
      end
   endtask

   task automatic run_row(input row_t r, input int i);
      logic [13:0] prev;
      prev = r.b ? prev_b : prev_a;
      drive(r.b, r.en, r.valid, r.data);
      #1;
      chk($sformatf("row%0d s_ready", i), 32'(r.b ? b_ready : a_ready), 32'(r.ready));
      @(posedge clk); #1;
      chk($sformatf("row%0d streaming", i), 32'(r.b ? b_stream : a_stream), 32'(r.strm));
      chk($sformatf("row%0d dac_word", i), 32'(r.b ? b_word : a_word), 32'(r.word));
      chk($sformatf("row%0d underrun_cnt", i), 32'(r.b ? b_cnt : a_cnt), 32'(r.cnt));
      chk($sformatf("row%0d lanes_rise", i), 32'(r.b ? b_lanes : a_lanes), 32'(even_bits(prev)));
      if (r.b) prev_b = r.word; else prev_a = r.word;
   endtask

   task automatic step_a(input logic en, input logic v, input logic [13:0] d);
      drive(1'b0, en, v, d);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0; a_tp = 1'b0; b_tp = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 14'd0);
      drive(1'b1, 1'b0, 1'b0, 14'd0);
      prev_a = 14'h0000; prev_b = 14'h2000;

      // A: streaming start, ordered output, underrun with hold, disable
      add(0, 1, 0, 14'd0,   1, 0, 14'd0,   16'd0);
      add(0, 1, 1, 14'd100, 1, 0, 14'd0,   16'd0);
      add(0, 1, 1, 14'd200, 1, 0, 14'd0,   16'd0);
      add(0, 1, 1, 14'd300, 1, 0, 14'd0,   16'd0);
      add(0, 1, 1, 14'd400, 1, 0, 14'd0,   16'd0);
      add(0, 1, 0, 14'd0,   1, 1, 14'd0,   16'd0);
      add(0, 1, 0, 14'd0,   1, 1, 14'd100, 16'd0);
      add(0, 1, 0, 14'd0,   1, 1, 14'd200, 16'd0);
      add(0, 1, 0, 14'd0,   1, 1, 14'd300, 16'd0);
      add(0, 1, 0, 14'd0,   1, 1, 14'd400, 16'd0);
      add(0, 1, 0, 14'd0,   1, 0, 14'd400, 16'd1);
      add(0, 1, 0, 14'd0,   1, 0, 14'd400, 16'd1);
      add(0, 1, 0, 14'd0,   1, 0, 14'd400, 16'd1);
      add(0, 0, 0, 14'd0,   0, 0, 14'd0,   16'd1);
      // B: offset binary, prime to full, back-pressure, mid-scale on underrun
      add(1, 1, 0, 14'd0,     1, 0, 14'h2000, 16'd0);
      add(1, 1, 1, 14'h2000,  1, 0, 14'h2000, 16'd0);
      for (int k = 0; k < 7; k++) add(1, 1, 1, 14'(k), 1, 0, 14'h2000, 16'd0);
      add(1, 1, 1, 14'd99,    0, 1, 14'h2000, 16'd0);
      add(1, 1, 0, 14'd0,     0, 1, 14'h0000, 16'd0);
      for (int k = 0; k < 7; k++) add(1, 1, 0, 14'd0, 1, 1, 14'h2000 + 14'(k), 16'd0);
      add(1, 1, 0, 14'd0,     1, 0, 14'h2000, 16'd1);
      add(1, 1, 0, 14'd0,     1, 0, 14'h2000, 16'd1);
      add(1, 0, 0, 14'd0,     0, 0, 14'h2000, 16'd1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst a_word", 32'(a_word), 32'h0000);
      chk("rst b_word", 32'(b_word), 32'h2000);
      chk("rst streaming", 32'(a_stream), 32'd0);
      chk("rst underrun_cnt", 32'(a_cnt), 32'd0);
      chk("rst a_lanes_rise", 32'(a_lanes), 32'(even_bits(14'h0000)));
      chk("rst b_lanes_rise", 32'(b_lanes), 32'(even_bits(14'h2000)));
      a_en = 1'b1; #1;
      chk("rst s_ready gated", 32'(a_ready), 32'd0);
      a_en = 1'b0;
      @(negedge clk); #1;
      chk("rst b_lanes_fall", 32'(b_lanes), 32'(odd_bits(14'h2000)));
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

      // en dropped with samples queued, then fresh priming
      step_a(1, 0, 14'd0);
      foreach (tbl[i]) if (i < 5) step_a(1, 1, 14'd10 * 14'(i + 1));
      chk("drop streaming", 32'(a_stream), 32'd1);
      step_a(1, 0, 14'd0);
      step_a(1, 0, 14'd0);
      chk("drop word20", 32'(a_word), 32'd20);
      @(negedge clk); #1;
      chk("drop lanes_fall", 32'(a_lanes), 32'(odd_bits(14'd10)));
      step_a(0, 0, 14'd0);
      chk("drop idle streaming", 32'(a_stream), 32'd0);
      chk("drop idle word", 32'(a_word), 32'd0);
      repeat (3) step_a(1, 0, 14'd0);
      chk("reprime streaming", 32'(a_stream), 32'd0);
      for (int k = 1; k <= 4; k++) step_a(1, 1, 14'(k));
      step_a(1, 0, 14'd0);
      step_a(1, 0, 14'd0);
      chk("reprime first word", 32'(a_word), 32'd1);

      // reset mid-stream with 3 samples still queued
      #2 rst = 1'b0; #1;
      chk("midrst word", 32'(a_word), 32'd0);
      chk("midrst streaming", 32'(a_stream), 32'd0);
      chk("midrst underrun_cnt", 32'(a_cnt), 32'd0);
      chk("midrst s_ready", 32'(a_ready), 32'd0);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      for (int k = 7; k <= 10; k++) step_a(1, 1, 14'(k));
      step_a(1, 0, 14'd0);
      chk("postrst streaming", 32'(a_stream), 32'd1);
      step_a(1, 0, 14'd0);
      chk("postrst first word", 32'(a_word), 32'd7);

`ifdef DAC_TESTPAT_EN
      step_a(0, 0, 14'd0);
      step_a(1, 0, 14'd0);
      repeat (4) step_a(1, 1, 14'h3FFE);
      step_a(1, 0, 14'd0);
      step_a(1, 0, 14'd0);
      chk("tp start", 32'(a_word), 32'h3FFE);
      a_tp = 1'b1;
      step_a(1, 0, 14'd0);
      chk("tp 3FFF", 32'(a_word), 32'h3FFF);
      step_a(1, 0, 14'd0);
      chk("tp wrap", 32'(a_word), 32'h0000);
      step_a(1, 0, 14'd0);
      chk("tp 0001", 32'(a_word), 32'h0001);
      a_tp = 1'b0;
      step_a(1, 0, 14'd0);
      chk("tp no pop", 32'(a_word), 32'h3FFE);
      chk("tp streaming", 32'(a_stream), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
